// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
//   state_t      : scheduler FSM states
//   idx_w()      : requester index width, never below 1 bit
//   DEF_*        : default sizing/timing values used by the top-level parameters
package spi_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_t;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_REQ);
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_W      = 4;
  localparam int DEF_GAP_CYCLES = 25;
  localparam int DEF_BUSY_TO    = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin requester pick.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   grant_en   : commit the current pick (moves the pointer onto the winner)
//   pick       : one-hot winner, combinational; search starts at pointer+1
// The pointer resets to NUM_REQ-1 so requester 0 wins the first arbitration.
module spi_rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] pick
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  logic             f_all;
  logic             f_hi;
  int               lo_all;
  int               lo_hi;

  // Lowest requester above the pointer wins; if none, wrap to lowest overall.
  always_comb begin
    f_all  = 1'b0;
    f_hi   = 1'b0;
    lo_all = 0;
    lo_hi  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_all = i;
        f_all  = 1'b1;
        if (i > int'(ptr)) begin
          lo_hi = i;
          f_hi  = 1'b1;
        end
      end
    end
    sel  = f_hi ? IDX_W'(lo_hi) : IDX_W'(lo_all);
    pick = f_all ? (NUM_REQ'(1) << sel) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= IDX_W'(NUM_REQ - 1);
    else if (grant_en && f_all) ptr <= sel;
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Arbitrates NUM_REQ requesters onto one spi_master and sequences their bursts.
//   clk, rst_n          : clock, async active-low reset
//   req/req_rd/req_len  : request level, read flag, frame count (sampled at grant)
//   wr_data             : per-requester next TX byte
//   gnt                 : one-hot owner, held for the whole burst
//   wr_ack / rd_valid   : per-owner byte captured / rd_data updated pulses
//   rd_data             : last byte received
//   done / err          : burst end pulse / timeout flag alongside done
//   spi_*               : spi_master start strobes, tx byte, rx byte, busy
// Flow per frame: LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> (GAP -> LOAD | FINISH).
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int BUSY_TO    = DEF_BUSY_TO
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            wr_ack,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic                          spi_start_tx,
  output logic                          spi_start_rx,
  output logic [DATA_WIDTH-1:0]         spi_tx_data,
  input  logic [DATA_WIDTH-1:0]         spi_rx_data,
  input  logic                          spi_busy
);

  localparam int TO_W  = $clog2(BUSY_TO + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t state, nxt;

  logic [NUM_REQ-1:0][LEN_W-1:0]      len_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_arr;
  logic [NUM_REQ-1:0]                 pick;
  logic                               grant_en;
  logic [LEN_W-1:0]                   pick_len, len_q, cnt, cnt_inc;
  logic                               pick_rd, rd_q, err_q;
  logic [DATA_WIDTH-1:0]              own_wr;
  logic [TO_W-1:0]                    to_cnt;
  logic [GAP_W-1:0]                   gap_cnt;
  logic                               to_hit, gap_hit;

  assign len_arr = req_len;
  assign wr_arr  = wr_data;

  // Foreign activity on the bus blocks arbitration entirely.
  assign grant_en = (state == S_IDLE) && (|req) && !spi_busy;
  assign cnt_inc  = cnt + LEN_W'(1);
  assign to_hit   = (to_cnt == TO_W'(BUSY_TO - 1));
  assign gap_hit  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant_en (grant_en),
    .pick     (pick)
  );

  // One-hot muxes: candidate's len/rd at arbitration, owner's byte at LOAD.
  always_comb begin
    pick_len = '0;
    pick_rd  = 1'b0;
    own_wr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_len = len_arr[i];
        pick_rd  = req_rd[i];
      end
      own_wr = own_wr | (wr_arr[i] & {DATA_WIDTH{gnt[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    wr_ack       = '0;
    spi_start_tx = 1'b0;
    spi_start_rx = 1'b0;
    done         = '0;
    err          = '0;
    case (state)
      S_IDLE:      if (grant_en) nxt = (pick_len == '0) ? S_FINISH : S_LOAD;
      S_LOAD: begin
        if (!rd_q) wr_ack = gnt;
        nxt = S_START;
      end
      S_START: begin
        spi_start_tx = !rd_q;
        spi_start_rx = rd_q;
        nxt          = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_busy)    nxt = S_WAIT_DONE;
        else if (to_hit) nxt = S_FINISH;
      end
      // A busy glitch still completes the frame here; the follow-up 1 lands in GAP.
      S_WAIT_DONE: if (!spi_busy) nxt = (cnt_inc == len_q) ? S_FINISH : S_GAP;
      S_GAP:       if (gap_hit) nxt = S_LOAD;
      S_FINISH: begin
        done = gnt;
        err  = err_q ? gnt : '0;
        nxt  = S_IDLE;
      end
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      len_q       <= '0;
      rd_q        <= 1'b0;
      cnt         <= '0;
      err_q       <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      spi_tx_data <= '0;
      rd_data     <= '0;
      rd_valid    <= '0;
    end else begin
      // rd_data and rd_valid become visible together, one cycle after busy falls.
      rd_valid <= (state == S_WAIT_DONE && !spi_busy && rd_q) ? gnt : '0;
      case (state)
        S_IDLE: if (grant_en) begin
          gnt   <= pick;
          len_q <= pick_len;
          rd_q  <= pick_rd;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        S_LOAD: begin
          spi_tx_data <= rd_q ? '0 : own_wr;
          to_cnt      <= '0;
        end
        S_WAIT_BUSY: if (!spi_busy) begin
          if (to_hit) err_q <= 1'b1;
          if (to_cnt != TO_W'(BUSY_TO)) to_cnt <= to_cnt + TO_W'(1);
        end
        S_WAIT_DONE: if (!spi_busy) begin
          cnt     <= cnt_inc;
          gap_cnt <= '0;
          if (rd_q) rd_data <= spi_rx_data;
        end
        S_GAP:    gap_cnt <= gap_cnt + GAP_W'(1);
        S_FINISH: gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a small spi_master stand-in:
// the stub raises busy on the negedge a start strobe is seen, holds it for
// busy_len negedges, then drops it and presents rx_tab[frame number].
module tb_spi_txn_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req_rd;
  logic [7:0] req_len;
  logic [15:0] wr_data;
  logic [1:0] gnt, wr_ack, rd_valid, done, err;
  logic [7:0] rd_data, spi_tx_data;
  logic [7:0] spi_rx_data = 8'h00;
  logic       spi_start_tx, spi_start_rx, spi_busy;

  logic       stub_busy = 1'b0;
  logic       foreign_busy;
  logic       stub_en;
  int         busy_len;
  int         stub_cnt = 0;
  int         stub_nfr = 0;
  logic [7:0] rx_tab [0:15];

  int cyc = 0;
  int n_tx = 0, n_rx = 0, n_err = 0, n_badgnt = 0;
  int start_q[$], ack_q[$], done_q[$];
  logic [7:0] rdv_q[$];

  int n_tests = 0, n_fail = 0;
  int tx0, rx0, ak0, sq, rq, aq, dq;

  assign spi_busy = stub_busy | foreign_busy;

  always #5 clk = ~clk;

  spi_txn_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_rd       (req_rd),
    .req_len      (req_len),
    .wr_data      (wr_data),
    .gnt          (gnt),
    .wr_ack       (wr_ack),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .done         (done),
    .err          (err),
    .spi_start_tx (spi_start_tx),
    .spi_start_rx (spi_start_rx),
    .spi_tx_data  (spi_tx_data),
    .spi_rx_data  (spi_rx_data),
    .spi_busy     (spi_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stub_en && (spi_start_tx || spi_start_rx)) begin
      stub_busy = 1'b1;
      stub_cnt  = busy_len;
    end else if (stub_busy) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        spi_rx_data = rx_tab[stub_nfr & 15];
        stub_nfr++;
        stub_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (spi_start_tx) begin n_tx++; start_q.push_back(cyc); end
    if (spi_start_rx) begin n_rx++; start_q.push_back(cyc); end
    for (int i = 0; i < 2; i++) begin
      if (wr_ack[i]) ack_q.push_back(i);
      if (done[i])   done_q.push_back(i);
    end
    if (|err) n_err++;
    if (|rd_valid) rdv_q.push_back(rd_data);
    if ($countones(gnt) > 1) n_badgnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(|done) && k < budget);
    check(tag, 32'(|done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; req_rd = '0; req_len = '0; wr_data = '0;
    foreign_busy = 1'b0; stub_en = 1'b1; busy_len = 4;
    for (int i = 0; i < 16; i++) rx_tab[i] = 8'h00;
    rx_tab[1] = 8'h5A; rx_tab[2] = 8'h3C; rx_tab[3] = 8'hFF;

    // Reset values
    #2;
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_stx",   32'(spi_start_tx), 32'h0);
    check("rst_srx",   32'(spi_start_rx), 32'h0);
    check("rst_txd",   32'(spi_tx_data), 32'h0);
    check("rst_rdv",   32'(rd_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, requester 0
    req_len[3:0] = 4'd1; wr_data[7:0] = 8'hA5; req = 2'b01;
    @(negedge clk);
    check("t1_load_ack", 32'(wr_ack), 32'h1);
    check("t1_load_gnt", 32'(gnt), 32'h1);
    check("t1_load_stx", 32'(spi_start_tx), 32'h0);
    @(negedge clk);
    check("t1_stx",   32'(spi_start_tx), 32'h1);
    check("t1_srx",   32'(spi_start_rx), 32'h0);
    check("t1_txd",   32'(spi_tx_data), 32'hA5);
    req = 2'b00;
    repeat (4) @(negedge clk);
    check("t1_early_done", 32'(done), 32'h0);
    @(negedge clk);
    check("t1_done", 32'(done), 32'h1);
    check("t1_err",  32'(err), 32'h0);
    @(negedge clk);
    check("t1_gnt_clr", 32'(gnt), 32'h0);
    check("t1_nack",    32'(ack_q.size()), 32'd1);
    check("t1_ntx",     32'(n_tx), 32'd1);

    // Read burst of 3, requester 1
    tx0 = n_tx; rx0 = n_rx; rq = rdv_q.size(); sq = start_q.size(); ak0 = n_err;
    req_rd = 2'b10; req_len[7:4] = 4'd3; req = 2'b10;
    wait_done("t2_wait", 400);
    check("t2_done",  32'(done), 32'h2);
    check("t2_rdv",   32'(rd_valid), 32'h2);
    check("t2_rdata", 32'(rd_data), 32'hFF);
    req = 2'b00;
    @(negedge clk);
    check("t2_nrx",   n_rx - rx0, 32'd3);
    check("t2_ntx",   n_tx - tx0, 32'd0);
    check("t2_nrdv",  32'(rdv_q.size() - rq), 32'd3);
    check("t2_rd0",   32'(rdv_q[rq]),   32'h5A);
    check("t2_rd1",   32'(rdv_q[rq+1]), 32'h3C);
    check("t2_rd2",   32'(rdv_q[rq+2]), 32'hFF);
    check("t2_sep0",  start_q[sq+1] - start_q[sq],   32'd31);
    check("t2_sep1",  start_q[sq+2] - start_q[sq+1], 32'd31);
    check("t2_noerr", n_err - ak0, 32'd0);

    // Contention: both request len=2 writes
    req_rd = 2'b00; req_len = {4'd2, 4'd2}; wr_data = {8'h22, 8'h11};
    tx0 = n_tx; aq = ack_q.size(); dq = done_q.size();
    req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_done("t3_wait", 400);
      if (b == 3) req = 2'b00;
    end
    @(negedge clk);
    check("t3_gnt_clr", 32'(gnt), 32'h0);
    check("t3_ndone",   32'(done_q.size() - dq), 32'd4);
    for (int b = 0; b < 4; b++) check("t3_order", 32'(done_q[dq+b]), 32'(b & 1));
    check("t3_nack",    32'(ack_q.size() - aq), 32'd8);
    for (int k = 0; k < 8; k++) check("t3_ack_own", 32'(ack_q[aq+k]), 32'((k >> 1) & 1));
    check("t3_ntx",     n_tx - tx0, 32'd8);
    check("t3_onehot",  n_badgnt, 32'd0);

    // Busy timeout: no spi_master response
    stub_en = 1'b0; req_len[3:0] = 4'd2; wr_data[7:0] = 8'h3C;
    tx0 = n_tx;
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("t4_stx", 32'(spi_start_tx), 32'h1);
    req = 2'b00;
    repeat (16) @(negedge clk);
    check("t4_early_done", 32'(done), 32'h0);
    @(negedge clk);
    check("t4_done", 32'(done), 32'h1);
    check("t4_err",  32'(err), 32'h1);
    @(negedge clk);
    check("t4_idle", 32'(gnt), 32'h0);
    check("t4_ntx",  n_tx - tx0, 32'd1);
    stub_en = 1'b1;

    // Zero length
    req_len[3:0] = 4'd0;
    tx0 = n_tx; rx0 = n_rx; aq = ack_q.size();
    req = 2'b01;
    @(negedge clk);
    check("t5_done", 32'(done), 32'h1);
    check("t5_err",  32'(err), 32'h0);
    req = 2'b00;
    @(negedge clk);
    check("t5_done_clr", 32'(done), 32'h0);
    check("t5_nostart",  (n_tx - tx0) + (n_rx - rx0), 32'd0);
    check("t5_noack",    32'(ack_q.size() - aq), 32'd0);

    // Foreign busy holds off arbitration
    foreign_busy = 1'b1; req_len[7:4] = 4'd1; req = 2'b10;
    repeat (4) @(negedge clk);
    check("t6_hold_gnt", 32'(gnt), 32'h0);
    foreign_busy = 1'b0;
    @(negedge clk);
    check("t6_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    wait_done("t6_wait", 100);
    check("t6_done", 32'(done), 32'h2);
    @(negedge clk);

    // Reset during WAIT_DONE of frame 2
    req_len[3:0] = 4'd3; wr_data[7:0] = 8'h77;
    tx0 = n_tx;
    req = 2'b01;
    repeat (35) @(negedge clk);
    check("t7_mid_gnt", 32'(gnt), 32'h1);
    check("t7_mid_txd", 32'(spi_tx_data), 32'h77);
    check("t7_mid_ntx", n_tx - tx0, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_gnt",  32'(gnt), 32'h0);
    check("t7_rst_ack",  32'(wr_ack), 32'h0);
    check("t7_rst_done", 32'(done), 32'h0);
    check("t7_rst_stx",  32'(spi_start_tx), 32'h0);
    check("t7_rst_txd",  32'(spi_tx_data), 32'h0);
    check("t7_rst_rd",   32'(rd_data), 32'h0);
    dq = done_q.size();
    req = 2'b11; req_len = {4'd1, 4'd1};
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_regrant", 32'(gnt), 32'h1);
    check("t7_nodone",  32'(done_q.size() - dq), 32'd0);
    req = 2'b00;
    wait_done("t7_wait", 100);
    check("t7_done", 32'(done), 32'h1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
- Sequencer and arbiter in front of a single spi_master instance; shares it between NUM_REQ requesters.
- Each granted requester gets a burst of 1..2^LEN_W-1 frames. Each frame is either a write (start_tx) or a read (start_rx).
- The block issues start pulses, tracks busy, inserts inter-frame gaps, streams bytes, and reports completion and timeout per requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 8, SPI frame width; must match spi_master
- LEN_W, 4, width of the per-requester burst-length field
- GAP_CYCLES, 25, idle clk cycles between frames of one burst (>=1)
- BUSY_TO, 16, max clk cycles from start pulse to busy=1 before a timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  request, level; sampled only during arbitration
- req_rd  in  NUM_REQ  1 = read burst (start_rx), 0 = write burst (start_tx)
- req_len  in  NUM_REQ*LEN_W  frame count, slice i for requester i
- wr_data  in  NUM_REQ*DATA_WIDTH  next TX byte, slice i
- gnt  out  NUM_REQ  one-hot grant, held for the whole burst
- wr_ack  out  NUM_REQ  1-cycle pulse when a wr_data byte is captured
- rd_data  out  DATA_WIDTH  last received byte
- rd_valid  out  NUM_REQ  1-cycle pulse to the owner when rd_data is updated
- done  out  NUM_REQ  1-cycle pulse when a burst ends (normal or timeout)
- err  out  NUM_REQ  1-cycle pulse coincident with done on timeout
- spi_start_tx  out  1  to spi_master.start_tx
- spi_start_rx  out  1  to spi_master.start_rx
- spi_tx_data  out  DATA_WIDTH  to spi_master.tx_data, held stable from LOAD until busy falls
- spi_rx_data  in  DATA_WIDTH  from spi_master.rx_data
- spi_busy  in  1  from spi_master.busy

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, rr pointer = NUM_REQ-1 (so requester 0 wins first), frame counter 0.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, FINISH.
- IDLE:
  - if any req bit is set, the round-robin pick starts at pointer+1.
  - the chosen requester gets gnt, a latched len and a latched rd flag; the pointer updates to it. Next state LOAD.
  - a latched len of 0 goes straight to FINISH with no SPI activity and no err.
- LOAD (1 cycle):
  - write burst: spi_tx_data <= wr_data slice, wr_ack pulses this cycle.
  - read burst: spi_tx_data <= 0.
  - next state START.
- START (exactly 1 cycle): spi_start_tx=1 for a write or spi_start_rx=1 for a read, never both. Next state WAIT_BUSY.
- WAIT_BUSY:
  - spi_busy=1 -> WAIT_DONE.
  - otherwise count; after BUSY_TO cycles -> FINISH with the err flag set.
- WAIT_DONE:
  - on spi_busy=0, increment the frame count.
  - read burst: capture spi_rx_data into rd_data the same cycle and pulse rd_valid next cycle.
  - if count == len -> FINISH, else -> GAP.
- GAP: hold GAP_CYCLES cycles, then -> LOAD.
- FINISH (1 cycle): pulse done (and err if flagged), clear gnt, then -> IDLE. The first re-arbitration is the cycle after FINISH, so there is a minimum 1 idle cycle between bursts.
- Latency: IDLE with req=1 gives spi_start_* exactly 3 cycles later (arb, LOAD, START).
- Boundaries:
  - req deasserted mid-burst does not abort; the burst runs to len.
  - req_len and req_rd changes after grant are ignored.
  - A requester asserting req again in the FINISH cycle is only considered after others under round-robin; if it is alone, it is re-granted.
  - spi_busy already 1 in IDLE (foreign activity): no grant until it is 0.
  - A spi_busy glitch 1->0->1 within WAIT_DONE counts as one frame completion; the next frame waits for GAP.
  - rst_n low mid-burst: immediate return to reset values, no done pulse; the owner must re-request.
- Width rules: the frame counter is LEN_W bits, compared for equality with len and never wraps within a burst; the BUSY_TO counter saturates.

Decomposition:
- Package spi_sched_pkg: FSM state enum, index width localparam clog2(NUM_REQ), default timing constants.
- One sub-module, spi_rr_arbiter: combinational one-hot round-robin pick from req and the pointer, plus a registered pointer update on grant_en.

Test Plan:
- Single write: req[0]=1, rd=0, len=1, wr_data=0xA5 -> one spi_start_tx pulse, spi_tx_data=0xA5, wr_ack[0] once, done[0] one cycle after busy falls, err=0.
- Read burst: req[1]=1, rd=1, len=3, slave returns 0x5A, 0x3C, 0xFF -> three spi_start_rx pulses separated by >=GAP_CYCLES, rd_valid[1] x3 with those values, done[1] once.
- Contention: req=2'b11 held, len=2 each -> grant order 0,1,0,1; no frames interleaved between bursts; 4 done pulses total.
- Timeout: stub spi_busy stuck 0, len=2 -> after START+16 cycles done[0] and err[0] pulse together, only one start pulse, back in IDLE.
- Zero length: req[0]=1, len=0 -> done[0] pulse with no spi_start_* and no wr_ack.
- Reset mid-burst: assert rst_n=0 during WAIT_DONE of frame 2 of a len=3 burst -> all outputs 0 asynchronously, no done; after release, grant goes to requester 0.
